// File: rtl/m_inst_encoder_pkg.sv
// Shared definitions for the RV32I instruction assembler: format codes,
// common opcodes and the filler word used for rejected entries.
package m_inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0]  OP_IMM    = 7'h13;
  localparam logic [6:0]  OP_STORE  = 7'h23;
  localparam logic [6:0]  OP_BRANCH = 7'h63;
  localparam logic [6:0]  OP_LUI    = 7'h37;
  localparam logic [6:0]  OP_JAL    = 7'h6F;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

endpackage

// File: rtl/m_inst_encoder_if.sv
// Stream interface of the encoder: decoded-field input, address reload
// and packed-instruction output. The encoder takes the slave side.
interface m_inst_encoder_if #(
  parameter int ERR_W = 8
);
  import m_inst_encoder_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [2:0]               in_fmt;
  logic [6:0]               in_opcode;
  logic [4:0]               in_rd;
  logic [4:0]               in_rs1;
  logic [4:0]               in_rs2;
  logic [2:0]               in_funct3;
  logic [6:0]               in_funct7;
  logic signed [31:0]       in_imm;
  logic                     addr_load;
  logic [31:0]              addr_val;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_inst;
  logic [31:0]              out_addr;
  logic                     out_err;
  logic [ERR_W-1:0]         err_cnt;

  modport master (
    output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, addr_load, addr_val, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );

  modport slave (
    input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3,
           in_funct7, in_imm, addr_load, addr_val, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err, err_cnt
  );

endinterface

// File: rtl/m_imm_pack.sv
// Scatters a value-form immediate into its instruction-field positions
// for each format and flags values the format cannot represent.
module m_imm_pack
  import m_inst_encoder_pkg::*;
(
  input  logic [2:0]         fmt,
  input  logic signed [31:0] imm,
  output logic [31:0]        imm_bits,
  output logic               imm_err
);

  // True when v fits in a two's-complement field of the given width.
  function automatic logic in_range(input logic signed [31:0] v, input int bits);
    logic signed [31:0] lim;
    lim = 32'sd1 <<< (bits - 1);
    return (v >= -lim) && (v < lim);
  endfunction

  // Per-format bit scatter and legality check.
  always_comb begin
    imm_bits = '0;
    imm_err  = 1'b0;
    case (fmt)
      FMT_R: ;
      FMT_I: begin
        imm_bits[31:20] = imm[11:0];
        imm_err         = !in_range(imm, 12);
      end
      FMT_S: begin
        imm_bits[31:25] = imm[11:5];
        imm_bits[11:7]  = imm[4:0];
        imm_err         = !in_range(imm, 12);
      end
      FMT_B: begin
        imm_bits[31]    = imm[12];
        imm_bits[30:25] = imm[10:5];
        imm_bits[11:8]  = imm[4:1];
        imm_bits[7]     = imm[11];
        imm_err         = !in_range(imm, 13) || imm[0];
      end
      FMT_U: begin
        imm_bits[31:12] = imm[31:12];
        imm_err         = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        imm_bits[31]    = imm[20];
        imm_bits[30:21] = imm[10:1];
        imm_bits[20]    = imm[11];
        imm_bits[19:12] = imm[19:12];
        imm_err         = !in_range(imm, 21) || imm[0];
      end
      default: imm_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/m_inst_encoder.sv
// Streaming RV32I assembler: packs decoded fields into a 32-bit word,
// tags it with a running address and replaces illegal entries with a NOP.
// One output register gives 1-cycle latency at full throughput.
module m_inst_encoder
  import m_inst_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = m_inst_encoder_pkg::NOP_INST,
  parameter int          ERR_W     = 8
)(
  input  logic           clk,
  input  logic           rst,
  m_inst_encoder_if.slave bus
);

  logic [31:0]      imm_bits;
  logic             imm_err;
  logic [31:0]      word_p0;
  logic             in_fire;
  logic             vld_p1;
  logic [31:0]      inst_p1;
  logic [31:0]      addr_p1;
  logic             err_p1;
  logic [31:0]      addr_cnt;
  logic [ERR_W-1:0] err_cnt_q;

  // Saturating increment so the error count never wraps back to zero.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  m_imm_pack u_imm_pack (
    .fmt      (bus.in_fmt),
    .imm      (bus.in_imm),
    .imm_bits (imm_bits),
    .imm_err  (imm_err)
  );

  // Stage p0: merge the register/funct fields with the scattered immediate.
  always_comb begin
    word_p0 = NOP_INST;
    case (bus.in_fmt)
      FMT_R:        word_p0 = {bus.in_funct7, bus.in_rs2, bus.in_rs1,
                               bus.in_funct3, bus.in_rd, bus.in_opcode};
      FMT_I:        word_p0 = imm_bits | {12'd0, bus.in_rs1, bus.in_funct3,
                                          bus.in_rd, bus.in_opcode};
      FMT_S, FMT_B: word_p0 = imm_bits | {7'd0, bus.in_rs2, bus.in_rs1,
                                          bus.in_funct3, 5'd0, bus.in_opcode};
      FMT_U, FMT_J: word_p0 = imm_bits | {20'd0, bus.in_rd, bus.in_opcode};
      default:      word_p0 = NOP_INST;
    endcase
    if (imm_err) word_p0 = NOP_INST;
  end

  assign bus.in_ready = !vld_p1 || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;

  // Stage p1: output register; holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      inst_p1 <= '0;
      addr_p1 <= BASE_ADDR;
      err_p1  <= 1'b0;
    end else if (in_fire) begin
      vld_p1  <= 1'b1;
      inst_p1 <= word_p0;
      addr_p1 <= addr_cnt;
      err_p1  <= imm_err;
    end else if (bus.out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  // Address counter: a reload wins over the post-transfer increment.
  always_ff @(posedge clk) begin
    if (rst)                addr_cnt <= BASE_ADDR;
    else if (bus.addr_load) addr_cnt <= bus.addr_val;
    else if (in_fire)       addr_cnt <= addr_cnt + 32'd4;
  end

  // Count accepted entries that were replaced by the NOP.
  always_ff @(posedge clk) begin
    if (rst)                     err_cnt_q <= '0;
    else if (in_fire && imm_err) err_cnt_q <= sat_inc(err_cnt_q);
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_inst  = inst_p1;
  assign bus.out_addr  = addr_p1;
  assign bus.out_err   = err_p1;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_m_inst_encoder.sv
// Self-checking bench for m_inst_encoder: expected entries are queued
// when an input is accepted and compared when the DUT hands them out.
module tb_m_inst_encoder;
  import m_inst_encoder_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic        err;
  } ent_t;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fld_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  m_inst_encoder_if #(.ERR_W(8)) bus();

  m_inst_encoder #(.BASE_ADDR(BASE), .NOP_INST(32'h0000_0013), .ERR_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          last_wait;
  logic [31:0] exp_addr;
  logic [7:0]  exp_errc;

  function automatic fld_t mk(logic [2:0] fmt, logic [6:0] op, logic [4:0] rd,
                              logic [4:0] rs1, logic [4:0] rs2, logic [2:0] f3,
                              logic [6:0] f7, logic [31:0] imm);
    fld_t f;
    f.fmt = fmt; f.op = op; f.rd = rd; f.rs1 = rs1; f.rs2 = rs2;
    f.f3 = f3; f.f7 = f7; f.imm = imm;
    return f;
  endfunction

  // Reference encoder: returns {err, inst}.
  function automatic logic [32:0] ref_enc(fld_t f);
    int          s;
    logic        err;
    logic [31:0] inst;
    logic [31:0] i;
    i = f.imm;
    s = $signed(f.imm);
    err = 1'b0;
    inst = 32'h0;
    case (f.fmt)
      3'd0: inst = {f.f7, f.rs2, f.rs1, f.f3, f.rd, f.op};
      3'd1: begin
        err  = (s < -2048) || (s > 2047);
        inst = {i[11:0], f.rs1, f.f3, f.rd, f.op};
      end
      3'd2: begin
        err  = (s < -2048) || (s > 2047);
        inst = {i[11:5], f.rs2, f.rs1, f.f3, i[4:0], f.op};
      end
      3'd3: begin
        err  = (s < -4096) || (s > 4095) || i[0];
        inst = {i[12], i[10:5], f.rs2, f.rs1, f.f3, i[4:1], i[11], f.op};
      end
      3'd4: begin
        err  = (i[11:0] != 12'd0);
        inst = {i[31:12], f.rd, f.op};
      end
      3'd5: begin
        err  = (s < -(1 << 20)) || (s >= (1 << 20)) || i[0];
        inst = {i[20], i[10:1], i[11], i[19:12], f.rd, f.op};
      end
      default: err = 1'b1;
    endcase
    if (err) inst = 32'h0000_0013;
    return {err, inst};
  endfunction

  // Output monitor: every handed-out entry must match the queue head.
  always @(negedge clk) begin
    ent_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL out_extra: unexpected entry inst=%h addr=%h err=%b",
                 bus.out_inst, bus.out_addr, bus.out_err);
      end else begin
        e = sb.pop_front();
        if ({bus.out_inst, bus.out_addr, bus.out_err} !== e) begin
          errors++;
          $display("FAIL out_entry: got inst=%h addr=%h err=%b, want inst=%h addr=%h err=%b",
                   bus.out_inst, bus.out_addr, bus.out_err, e.inst, e.addr, e.err);
        end
      end
    end
  end

  task automatic drive(input fld_t f);
    bus.in_fmt = f.fmt; bus.in_opcode = f.op; bus.in_rd = f.rd;
    bus.in_rs1 = f.rs1; bus.in_rs2 = f.rs2; bus.in_funct3 = f.f3;
    bus.in_funct7 = f.f7; bus.in_imm = f.imm;
  endtask

  task automatic send(input fld_t f, input logic [31:0] want_inst, input logic want_err,
                      input logic load, input logic [31:0] lval);
    bit done;
    done = 1'b0;
    last_wait = 0;
    drive(f);
    bus.in_valid = 1'b1;
    bus.addr_load = load;
    bus.addr_val = lval;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        sb.push_back({want_inst, exp_addr, want_err});
        exp_addr = load ? lval : exp_addr + 32'd4;
        if (want_err && exp_errc != 8'hFF) exp_errc++;
        done = 1'b1;
      end else begin
        last_wait++;
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.addr_load = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b after 50 cycles, want 1", bus.in_ready);
    end
  endtask

  task automatic send_ref(input fld_t f);
    logic [32:0] r;
    r = ref_enc(f);
    send(f, r[31:0], r[32], 1'b0, 32'h0);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int k = 0; k < 20 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%0d out_valid=%b, want 0 and 0", sb.size(), bus.out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: out_valid=%b out_err=%b, want 0 0", bus.out_valid, bus.out_err);
    end
    checks++;
    if (bus.out_inst !== 32'h0 || bus.out_addr !== BASE) begin
      errors++;
      $display("FAIL reset_data: out_inst=%h out_addr=%h, want 0 %h", bus.out_inst, bus.out_addr, BASE);
    end
    checks++;
    if (bus.err_cnt !== 8'h00 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cnt: err_cnt=%h in_ready=%b, want 00 1", bus.err_cnt, bus.in_ready);
    end
    rst = 1'b0;
    exp_addr = BASE;
    exp_errc = 8'h00;
  endtask

  task automatic test_back_to_back();
    int waits;
    waits = 0;
    bus.out_ready = 1'b1;
    send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    waits += last_wait;
    send(mk(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8), 32'h0020_A423, 1'b0, 1'b0, 32'h0);
    waits += last_wait;
    send(mk(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4), 32'hFE00_0EE3, 1'b0, 1'b0, 32'h0);
    waits += last_wait;
    send(mk(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000), 32'h1234_52B7, 1'b0, 1'b0, 32'h0);
    waits += last_wait;
    checks++;
    if (waits != 0) begin
      errors++;
      $display("FAIL b2b_throughput: stall cycles=%0d, want 0", waits);
    end
    drain();
  endtask

  task automatic test_jal_and_error();
    send(mk(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0800), 32'h0010_00EF, 1'b0, 1'b0, 32'h0);
    send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048), 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    drain();
    checks++;
    if (bus.err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL err_cnt_one: err_cnt=%0d, want 1", bus.err_cnt);
    end
  endtask

  task automatic test_backpressure();
    fld_t b;
    logic [31:0] a_addr;
    bus.out_ready = 1'b0;
    a_addr = exp_addr;
    send(mk(3'd1, 7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd7), 32'h0071_8113, 1'b0, 1'b0, 32'h0);
    b = mk(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'h0);
    drive(b);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_ready: in_ready=%b out_valid=%b, want 0 1", bus.in_ready, bus.out_valid);
      end
      checks++;
      if (bus.out_inst !== 32'h0071_8113 || bus.out_addr !== a_addr) begin
        errors++;
        $display("FAIL bp_hold: out_inst=%h out_addr=%h, want 00718113 %h", bus.out_inst, bus.out_addr, a_addr);
      end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send_ref(b);
    send_ref(mk(3'd2, 7'h23, 5'd0, 5'd7, 5'd8, 3'd1, 7'd0, -32'sd2048));
    drain();
  endtask

  task automatic test_addr_load();
    send(mk(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1), 32'h0010_0193, 1'b0, 1'b1, 32'h0000_0100);
    send_ref(mk(3'd4, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F000));
    drain();
    checks++;
    if (exp_addr !== 32'h0000_0104) begin
      errors++;
      $display("FAIL addr_track: counter=%h, want 00000104", exp_addr);
    end
  endtask

  task automatic test_random();
    fld_t f;
    for (int n = 0; n < 40; n++) begin
      f = mk(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
             5'($urandom), 3'($urandom), 7'($urandom), 32'h0);
      case ($urandom_range(0, 3))
        0: f.imm = $urandom;
        1: f.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: f.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFF_FFFE;
        default: f.imm = $urandom & 32'hFFFF_F000;
      endcase
      send_ref(f);
    end
    drain();
    checks++;
    if (bus.err_cnt !== exp_errc) begin
      errors++;
      $display("FAIL rand_err_cnt: err_cnt=%0d, want %0d", bus.err_cnt, exp_errc);
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 256; n++)
      send(mk(3'd7, 7'h13, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'h0), 32'h0000_0013, 1'b1, 1'b0, 32'h0);
    drain();
    checks++;
    if (bus.err_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL err_saturate: err_cnt=%h, want ff", bus.err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    send_ref(mk(3'd1, 7'h13, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9));
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.err_cnt !== 8'h00 || bus.out_addr !== BASE) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b err_cnt=%h out_addr=%h, want 0 00 %h",
               bus.out_valid, bus.err_cnt, bus.out_addr, BASE);
    end
    sb.delete();
    exp_addr = BASE;
    exp_errc = 8'h00;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(mk(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 32'h0050_0093, 1'b0, 1'b0, 32'h0);
    drain();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.addr_load = 1'b0; bus.addr_val = 32'h0;
    bus.out_ready = 1'b0;
    drive(mk(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0));
    exp_addr = BASE;
    exp_errc = 8'h00;
    test_reset();
    test_back_to_back();
    test_jal_and_error();
    test_backpressure();
    test_addr_load();
    test_random();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
